// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single memory port between three requesters:
//   0 = instruction fetch (read), 1 = loader FU (read), 2 = store commit (write).
// One transaction at a time, round-robin arbitration, hit/miss timing from the
// memory side. A flush squashes read owners: their access still runs to
// completion, but the ack and the rd_data update are suppressed.
//
// Ports
//   clk        single clock, all state on posedge
//   reset      asynchronous active-low reset
//   req        per-requester request level, held until ack
//   req_addr   packed addresses, requester i at [i*WORD_SIZE +: WORD_SIZE]
//   st_wdata   store data (requester 2)
//   flush      mispredict squash pulse
//   gnt        one-hot owner of the current transaction, 0 when idle
//   ack        one-cycle completion pulse to the owner
//   rd_data    read data, valid in the ack cycle, held between acks
//   busy       transaction in flight
//   mem_en/mem_we/mem_addr/mem_wdata  memory request side
//   mem_rdata/mem_hit                 memory response side (hit valid in ACCESS)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int MEM_STALL = 4,
    parameter int REQ_NUM   = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [REQ_NUM-1:0]           req,
    input  logic [REQ_NUM*WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]         st_wdata,
    input  logic                         flush,
    output logic [REQ_NUM-1:0]           gnt,
    output logic [REQ_NUM-1:0]           ack,
    output logic [WORD_SIZE-1:0]         rd_data,
    output logic                         busy,
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [WORD_SIZE-1:0]         mem_addr,
    output logic [WORD_SIZE-1:0]         mem_wdata,
    input  logic [WORD_SIZE-1:0]         mem_rdata,
    input  logic                         mem_hit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        STALL  = 2'd2
    } state_t;

    // Count value at which a miss completes: E0+1 enters STALL with cnt=1,
    // so the ack lands MEM_STALL edges after the grant.
    localparam logic [3:0] STALL_LAST = 4'(MEM_STALL - 1);

    state_t                 state_reg, state_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic [1:0]             last_gnt_reg, last_gnt_next;
    logic [REQ_NUM-1:0]     gnt_reg, gnt_next;
    logic [REQ_NUM-1:0]     ack_reg, ack_next;
    logic                   busy_reg, busy_next;
    logic                   mem_en_reg, mem_en_next;
    logic                   mem_we_reg, mem_we_next;
    logic [WORD_SIZE-1:0]   mem_addr_reg, mem_addr_next;
    logic [WORD_SIZE-1:0]   mem_wdata_reg, mem_wdata_next;
    logic [WORD_SIZE-1:0]   rd_data_reg, rd_data_next;
    // Remembers that a flush was seen while a read owned the port.
    logic                   flushed_reg, flushed_next;

    // Unpacked view of the request addresses.
    logic [WORD_SIZE-1:0]   addr_arr [REQ_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < REQ_NUM; gi++) begin : g_addr
            assign addr_arr[gi] = req_addr[gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin winner selection
    // ------------------------------------------------------------------
    logic [2:0] eligible;
    logic [1:0] start_idx;
    logic [2:0] pos;
    logic       win_valid;
    logic [1:0] win_idx;

    always_comb begin
        // Reads cannot win on a flush edge; stores always can.
        eligible  = req & (flush ? 3'b100 : 3'b111);
        start_idx = (last_gnt_reg == 2'd2) ? 2'd0 : last_gnt_reg + 2'd1;
        win_valid = 1'b0;
        win_idx   = 2'd0;
        pos       = 3'd0;
        for (int k = 0; k < 3; k++) begin
            pos = {1'b0, start_idx} + 3'(k);
            if (pos >= 3'd3) begin
                pos = pos - 3'd3;
            end
            if (!win_valid && eligible[pos[1:0]]) begin
                win_valid = 1'b1;
                win_idx   = pos[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    logic complete;
    logic suppress;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        last_gnt_next  = last_gnt_reg;
        gnt_next       = gnt_reg;
        ack_next       = '0;
        busy_next      = busy_reg;
        mem_en_next    = mem_en_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        rd_data_next   = rd_data_reg;
        flushed_next   = flushed_reg;
        complete       = 1'b0;
        suppress       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (win_valid) begin
                    state_next    = ACCESS;
                    gnt_next      = 3'b001 << win_idx;
                    busy_next     = 1'b1;
                    mem_en_next   = 1'b1;
                    mem_we_next   = (win_idx == 2'd2);
                    mem_addr_next = addr_arr[win_idx];
                    if (win_idx == 2'd2) begin
                        mem_wdata_next = st_wdata;
                    end
                    last_gnt_next = win_idx;
                    flushed_next  = 1'b0;
                    cnt_next      = 4'd0;
                end
            end
            ACCESS: begin
                flushed_next = flushed_reg | flush;
                if (mem_hit) begin
                    complete = 1'b1;
                end else begin
                    state_next = STALL;
                    cnt_next   = 4'd1;
                end
            end
            STALL: begin
                flushed_next = flushed_reg | flush;
                if (cnt_reg == STALL_LAST) begin
                    complete = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (complete) begin
            // A flush at the completion edge counts as well as earlier ones.
            suppress = !mem_we_reg && (flushed_reg || flush);
            ack_next = suppress ? '0 : gnt_reg;
            if (!mem_we_reg && !suppress) begin
                rd_data_next = mem_rdata;
            end
            gnt_next     = '0;
            busy_next    = 1'b0;
            mem_en_next  = 1'b0;
            mem_we_next  = 1'b0;
            cnt_next     = 4'd0;
            flushed_next = 1'b0;
            state_next   = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            last_gnt_reg  <= 2'd2;
            gnt_reg       <= '0;
            ack_reg       <= '0;
            busy_reg      <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rd_data_reg   <= '0;
            flushed_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_gnt_reg  <= last_gnt_next;
            gnt_reg       <= gnt_next;
            ack_reg       <= ack_next;
            busy_reg      <= busy_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            rd_data_reg   <= rd_data_next;
            flushed_reg   <= flushed_next;
        end
    end

    assign gnt       = gnt_reg;
    assign ack       = ack_reg;
    assign busy      = busy_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (WORD_SIZE=32, MEM_STALL=4). Inputs are
// driven and outputs sampled on the falling edge; expected values are written
// by hand from the cycle timing of each scenario.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [95:0] req_addr;
    logic [31:0] st_wdata;
    logic        flush;
    logic [2:0]  gnt;
    logic [2:0]  ack;
    logic [31:0] rd_data;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_hit;

    int checks;
    int errors;

    mem_port_arbiter #(
        .WORD_SIZE (32),
        .MEM_STALL (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .st_wdata  (st_wdata),
        .flush     (flush),
        .gnt       (gnt),
        .ack       (ack),
        .rd_data   (rd_data),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_hit   (mem_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: cross the active edge, land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int          own [4] = '{0, 1, 2, 0};
    logic [2:0]  oh;
    logic [31:0] exp_rd;

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        req       = 3'b000;
        req_addr  = '0;
        st_wdata  = '0;
        flush     = 1'b0;
        mem_rdata = '0;
        mem_hit   = 1'b1;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_gnt",   {29'd0, gnt}, 32'd0);
        check("rst_ack",   {29'd0, ack}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_en",    {31'd0, mem_en}, 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_rd",    rd_data, 32'd0);
        reset = 1'b1;

        // ---------------- T1: read hit, req dropped after grant ----------------
        req               = 3'b001;
        req_addr[0 +: 32] = 32'h10;
        mem_hit           = 1'b1;
        mem_rdata         = 32'hAB;
        step();  // E0
        check("t1_gnt",  {29'd0, gnt}, 32'b001);
        check("t1_en",   {31'd0, mem_en}, 32'd1);
        check("t1_we",   {31'd0, mem_we}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_addr", mem_addr, 32'h10);
        check("t1_ack0", {29'd0, ack}, 32'd0);
        req = 3'b000;
        step();  // E0+1
        check("t1_ack",  {29'd0, ack}, 32'b001);
        check("t1_rd",   rd_data, 32'hAB);
        check("t1_idle", {29'd0, gnt}, 32'd0);
        check("t1_en_off", {31'd0, mem_en}, 32'd0);
        $display("TXN t1 read req0 addr=10 rd=%h", rd_data);

        // ---------------- T2: store miss ----------------
        req                = 3'b100;
        req_addr[64 +: 32] = 32'h20;
        st_wdata           = 32'h55;
        mem_hit            = 1'b0;
        step();  // E0
        check("t2_gnt",   {29'd0, gnt}, 32'b100);
        check("t2_we0",   {31'd0, mem_we}, 32'd1);
        check("t2_addr",  mem_addr, 32'h20);
        check("t2_wdata", mem_wdata, 32'h55);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("t2_we_hold",  {31'd0, mem_we}, 32'd1);
            check("t2_ack_wait", {29'd0, ack}, 32'd0);
        end
        step();  // E0+4
        check("t2_ack", {29'd0, ack}, 32'b100);
        check("t2_we_off", {31'd0, mem_we}, 32'd0);
        check("t2_rd_keep", rd_data, 32'hAB);
        req = 3'b000;
        $display("TXN t2 store req2 addr=20 data=55");

        // ---------------- T5: flush in IDLE blocks reads ----------------
        flush              = 1'b1;
        req                = 3'b101;
        req_addr[0 +: 32]  = 32'h30;
        req_addr[64 +: 32] = 32'h40;
        st_wdata           = 32'h99;
        mem_hit            = 1'b1;
        mem_rdata          = 32'h77;
        step();  // E0: order would start at 0, but 0 is blocked
        check("t5_gnt2", {29'd0, gnt}, 32'b100);
        check("t5_addr2", mem_addr, 32'h40);
        flush = 1'b0;
        step();
        check("t5_ack2", {29'd0, ack}, 32'b100);
        check("t5_rd_keep", rd_data, 32'hAB);
        req = 3'b001;
        step();
        check("t5_gnt0", {29'd0, gnt}, 32'b001);
        check("t5_addr0", mem_addr, 32'h30);
        step();
        check("t5_ack0", {29'd0, ack}, 32'b001);
        check("t5_rd0", rd_data, 32'h77);
        req = 3'b000;
        $display("TXN t5 flush idle: req2 then req0 rd=%h", rd_data);

        // ---------------- T4: flush during STALL of read owner 1 ----------------
        req                = 3'b010;
        req_addr[32 +: 32] = 32'h50;
        mem_hit            = 1'b0;
        mem_rdata          = 32'hDEAD;
        step();  // E0
        check("t4_gnt", {29'd0, gnt}, 32'b010);
        step();  // E0+1 -> STALL
        check("t4_busy1", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        step();  // E0+2
        flush = 1'b0;
        check("t4_busy2", {31'd0, busy}, 32'd1);
        step();  // E0+3
        check("t4_busy3", {31'd0, busy}, 32'd1);
        step();  // E0+4: completes, ack squashed
        check("t4_ack", {29'd0, ack}, 32'd0);
        check("t4_done", {31'd0, busy}, 32'd0);
        check("t4_en_off", {31'd0, mem_en}, 32'd0);
        check("t4_rd_keep", rd_data, 32'h77);
        req = 3'b000;
        $display("TXN t4 flushed read req1 squashed");

        // ---------------- T6: reset during STALL ----------------
        req     = 3'b001;
        mem_hit = 1'b0;
        step();  // E0
        check("t6_gnt", {29'd0, gnt}, 32'b001);
        step();  // E0+1 -> STALL
        step();  // E0+2
        #2 reset = 1'b0;
        #1;
        check("t6_gnt_rst",  {29'd0, gnt}, 32'd0);
        check("t6_busy_rst", {31'd0, busy}, 32'd0);
        check("t6_en_rst",   {31'd0, mem_en}, 32'd0);
        check("t6_addr_rst", mem_addr, 32'd0);
        check("t6_rd_rst",   rd_data, 32'd0);
        req     = 3'b000;
        mem_hit = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_ack",  {29'd0, ack}, 32'd0);
            check("t6_no_busy", {31'd0, busy}, 32'd0);
        end
        $display("TXN t6 reset abort");

        // ---------------- T3: all requesting, order 0,1,2,0 ----------------
        req                = 3'b111;
        req_addr[0 +: 32]  = 32'h60;
        req_addr[32 +: 32] = 32'h64;
        req_addr[64 +: 32] = 32'h68;
        mem_hit            = 1'b1;
        exp_rd             = 32'd0;
        for (int i = 0; i < 4; i++) begin
            mem_rdata = 32'h100 + 32'(i);
            oh        = 3'b001 << own[i];
            step();
            check("t3_gnt", {29'd0, gnt}, {29'd0, oh});
            check("t3_we",  {31'd0, mem_we}, (own[i] == 2) ? 32'd1 : 32'd0);
            step();
            check("t3_ack",  {29'd0, ack}, {29'd0, oh});
            check("t3_idle", {29'd0, gnt}, 32'd0);
            if (own[i] != 2) begin
                exp_rd = 32'h100 + 32'(i);
            end
            check("t3_rd", rd_data, exp_rd);
            $display("TXN t3 grant req%0d rd=%h", own[i], rd_data);
        end
        req = 3'b000;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 32, data/address width.
REQ-002 Parameter MEM_STALL, default 4, cycles for a memory miss (legal range 2..15).
REQ-003 Parameter REQ_NUM, fixed 3; requesters: 0 = instruction fetch (read), 1 = loader FU (read), 2 = store commit (write).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  3  per-requester request level, held until its ack.
REQ-007 req_addr  input  3*WORD_SIZE  packed addresses; requester i at bits [i*WORD_SIZE +: WORD_SIZE].
REQ-008 st_wdata  input  WORD_SIZE  store data for requester 2.
REQ-009 flush  input  1  branch mispredict squash, one-cycle pulse.
REQ-010 gnt  output  3  one-hot owner of the current transaction; 0 when idle.
REQ-011 ack  output  3  one-cycle completion pulse to the owner.
REQ-012 rd_data  output  WORD_SIZE  read data, valid in the ack cycle.
REQ-013 busy  output  1  high while a transaction is in flight.
REQ-014 mem_en, mem_we  output  1 each  memory enable, write enable.
REQ-015 mem_addr, mem_wdata  output  WORD_SIZE each  memory address, write data.
REQ-016 mem_rdata  input  WORD_SIZE  memory read data; mem_hit  input  1  hit indication, valid during ACCESS.

Function
REQ-017 FSM states: IDLE, ACCESS, STALL; exactly one transaction at a time.
REQ-018 IDLE: at a posedge with any eligible req, latch the winner, set gnt, busy=1, mem_en=1, mem_we=(winner==2), mem_addr/mem_wdata from the winner, and go to ACCESS.
REQ-019 Eligible: req[i]=1, except that req[0] and req[1] are ineligible at a posedge where flush=1.
REQ-020 Arbitration is round-robin: search order starts at (last_gnt+1) mod 3; last_gnt updates at the grant edge.
REQ-021 ACCESS, mem_hit=1: at the next posedge, pulse ack[owner], capture rd_data=mem_rdata (reads only), clear gnt/busy/mem_en/mem_we, return to IDLE.
REQ-022 ACCESS, mem_hit=0: go to STALL with cnt=1; mem_en and the address/data stay asserted.
REQ-023 STALL: cnt increments each posedge; at the posedge with cnt==MEM_STALL-1, complete as in REQ-021.
REQ-024 Latency from the grant edge E0 to ack high: hit after E0+1; miss after E0+MEM_STALL.
REQ-025 The earliest new grant is at the posedge after the ack cycle (IDLE for at least one cycle between transactions).
REQ-026 Read requester 0/1 with flush=1 at any posedge while it owns a transaction: the memory access still runs to completion. Its ack and rd_data update are suppressed, and last_gnt still advances.
REQ-027 flush never cancels or suppresses a store (requester 2).
REQ-028 req deasserted mid-transaction is ignored; the transaction completes and ack still pulses.
REQ-029 rd_data holds its value between acks; it is not updated by stores.
REQ-030 cnt width is 4 bits; no wrap occurs within the legal MEM_STALL range.

Reset
REQ-031 On reset low, immediately: state=IDLE, cnt=0, last_gnt=2, gnt=0, ack=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0.
REQ-032 Reset low mid-transaction aborts it with no ack; after reset release, the first arbitration order is 0,1,2.

Verification
REQ-033 Setup: after reset, req=3'b001, addr0=0x10, mem_hit=1, mem_rdata=0xAB. Required: mem_en high after E0; ack=3'b001 and rd_data=0xAB after E0+1.
REQ-034 Setup: req=3'b100, st_wdata=0x55, addr2=0x20, mem_hit=0, MEM_STALL=4. Required: mem_we=1 for 4 cycles; ack=3'b100 after E0+4.
REQ-035 Setup: req=3'b111 held continuously, all hits. Required: grant sequence 0,1,2,0 with an idle cycle between each transaction.
REQ-036 Setup: owner is requester 1 on a miss, flush pulsed during STALL. Required: the transaction completes at the normal time, ack stays 0, and rd_data is unchanged.
REQ-037 Setup: flush=1 in IDLE with req=3'b101. Required: requester 2 is granted; requester 0 is blocked for that edge.
REQ-038 Setup: reset asserted low during STALL. Required: all outputs go to 0 immediately, with no ack after release.
